dbus_access_ctrl: RTL

//  Sequences one load/store per memory-stage instruction onto the data bus (dbus).

---
 rtl/dbus_access_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/dbus_access_ctrl.sv
// Data-bus access sequencer: issues one load/store per memory-stage instruction,
// holds it until data_ok, and returns the lane-aligned, extended load result.
module dbus_access_ctrl #(
  parameter int unsigned TIMEOUT = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic        flush,
  output logic        stall_o,
  output logic        done_o,
  output logic [63:0] rdata_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        dbus_valid,
  output logic [63:0] dbus_addr,
  output logic [2:0]  dbus_size,
  output logic [7:0]  dbus_strobe,
  output logic [63:0] dbus_data,
  input  logic        dbus_addr_ok,
  input  logic        dbus_data_ok,
  input  logic [63:0] dbus_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam bit             WD_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      addr_q, addr_d;
  logic [2:0]       f3_q, f3_d;
  logic             write_q, write_d;
  logic [7:0]       strobe_q, strobe_d;
  logic [63:0]      data_q, data_d;
  logic [63:0]      rdata_q, rdata_d;

  logic [2:0]  align_mask;
  logic [7:0]  lane_mask;
  logic        req_illegal;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;
  logic [63:0] rd_lane;
  logic [63:0] rd_ext;
  logic        drop_now;
  logic        wd_expire;

  // Address-accept is informational only; completion is tracked on data_ok.
  logic unused_addr_ok;
  assign unused_addr_ok = dbus_addr_ok;

  always_comb begin
    align_mask = 3'b000;
    lane_mask  = 8'h01;
    case (req_funct3[1:0])
      2'd0: begin align_mask = 3'b000; lane_mask = 8'h01; end
      2'd1: begin align_mask = 3'b001; lane_mask = 8'h03; end
      2'd2: begin align_mask = 3'b011; lane_mask = 8'h0F; end
      default: begin align_mask = 3'b111; lane_mask = 8'hFF; end
    endcase
  end

  assign req_illegal = (req_funct3 == 3'b111)
                     | (req_write & req_funct3[2])
                     | (|(req_addr[2:0] & align_mask));
  assign req_strobe  = req_write ? (lane_mask << req_addr[2:0]) : '0;
  assign req_data    = req_write ? (req_wdata << {req_addr[2:0], 3'b000}) : '0;

  always_comb begin
    rd_lane = dbus_rdata >> {addr_q[2:0], 3'b000};
    case (f3_q[1:0])
      2'd0:    rd_ext = f3_q[2] ? {56'd0, rd_lane[7:0]}
                                : {{56{rd_lane[7]}}, rd_lane[7:0]};
      2'd1:    rd_ext = f3_q[2] ? {48'd0, rd_lane[15:0]}
                                : {{48{rd_lane[15]}}, rd_lane[15:0]};
      2'd2:    rd_ext = f3_q[2] ? {32'd0, rd_lane[31:0]}
                                : {{32{rd_lane[31]}}, rd_lane[31:0]};
      default: rd_ext = rd_lane;
    endcase
  end

  // A flush coinciding with data_ok discards the result just like an earlier one.
  assign drop_now  = drop_q | flush;
  assign wd_expire = WD_EN && (state_q == S_BUSY) && !dbus_data_ok && (cnt_q == WD_LAST);

  always_comb begin
    state_d  = state_q;
    drop_d   = drop_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    f3_d     = f3_q;
    write_d  = write_q;
    strobe_d = strobe_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && !flush && !req_illegal) begin
          addr_d   = req_addr;
          f3_d     = req_funct3;
          write_d  = req_write;
          strobe_d = req_strobe;
          data_d   = req_data;
          drop_d   = 1'b0;
          cnt_d    = '0;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        drop_d = drop_now;
        if (dbus_data_ok) begin
          drop_d = 1'b0;
          cnt_d  = '0;
          if (drop_now) begin
            state_d = S_IDLE;
          end else begin
            rdata_d = write_q ? '0 : rd_ext;
            state_d = S_DONE;
          end
        end else if (wd_expire) begin
          drop_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (WD_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        drop_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      drop_q   <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      f3_q     <= '0;
      write_q  <= 1'b0;
      strobe_q <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      f3_q     <= f3_d;
      write_q  <= write_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
    end
  end

  assign dbus_valid  = (state_q == S_BUSY);
  assign dbus_addr   = addr_q;
  assign dbus_size   = {1'b0, f3_q[1:0]};
  assign dbus_strobe = strobe_q;
  assign dbus_data   = data_q;

  assign done_o     = (state_q == S_DONE) && !flush;
  assign rdata_o    = rdata_q;
  assign misalign_o = (state_q == S_IDLE) && req_valid && !flush && req_illegal;
  assign bus_err_o  = wd_expire;
  assign stall_o    = req_valid && !done_o && !misalign_o && !flush;

endmodule
